// File: rtl/timestamp_capture.sv
// Purpose: snapshot lpt/hpt timestamp counters into a FIFO on qualified event_in edges; CPU reads snapshots over the peripheral bus.
// Latency: event edge before clock k is written at edge k+2 (counter values of cycle k+2), visible from k+3; register reads are combinational.
// Backpressure: none on the event side; a capture while full with no pop is dropped and sets sticky overflow.
module timestamp_capture #(
    parameter int BASE_ADR   = 'h000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_peri,
    input  logic        reset,
    input  logic [9:0]  addr_peri,
    input  logic        access_peri,
    input  logic        wr_peri,
    input  logic        rd_peri,
    input  logic [17:0] do_peri,
    output logic [17:0] di_peri,
    input  logic [35:0] lpt_counter,
    input  logic [35:0] hpt_counter,
    input  logic        event_in,
    output logic        irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [6:0] BASE_BLK = 7'(BASE_ADR >> 3);

    // Event synchronizer and edge-detect delay flop
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          dly_q, dly_d;
    // Software-visible state
    logic [3:0]    ctrl_q, ctrl_d;
    logic          ovf_q, ovf_d;
    logic          irq_q, irq_d;
    // FIFO bookkeeping
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [71:0]   mem_q [FIFO_DEPTH];

    logic          sel, wr_sel, rise, fall, cap, full, not_empty, pop, push;
    logic [71:0]   head;
    logic [5:0]    count6;
    logic [17:0]   rd_dat;
    logic          unused_bits;

    assign unused_bits = ^do_peri[17:4];

    // Decode, edge qualification and FIFO push/pop decisions
    always_comb begin
        sel       = access_peri && (addr_peri[9:3] == BASE_BLK);
        wr_sel    = sel && wr_peri;
        rise      = sync2_q && !dly_q;
        fall      = !sync2_q && dly_q;
        cap       = ctrl_q[0] && ((rise && ctrl_q[1]) || (fall && ctrl_q[2]));
        full      = (count_q == CW'(FIFO_DEPTH));
        not_empty = (count_q != '0);
        pop       = sel && rd_peri && (addr_peri[2:0] == 3'd3) && not_empty;
        // When full, a same-cycle pop frees the slot the new entry lands in
        push      = cap && (!full || pop);
    end

    // Next-state for synchronizer, registers, pointers and count
    always_comb begin
        sync1_d  = event_in;
        sync2_d  = sync1_q;
        dly_d    = sync2_q;
        ctrl_d   = ctrl_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_sel && addr_peri[2:0] == 3'd5) begin
            ctrl_d = do_peri[3:0];
        end
        if (wr_sel && addr_peri[2:0] == 3'd4 && do_peri[2]) begin
            ovf_d = 1'b0;
        end
        // A drop in the same cycle as a clear still leaves overflow set
        if (cap && full && !pop) begin
            ovf_d = 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        irq_d = ctrl_q[3] && not_empty;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_peri or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            dly_q    <= 1'b0;
            ctrl_q   <= '0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            dly_q    <= dly_d;
            ctrl_q   <= ctrl_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Capture storage; contents are only observable while count is non-zero
    always_ff @(posedge clk_peri) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {lpt_counter, hpt_counter};
        end
    end

    // Combinational read mux; zero unless selected for read
    always_comb begin
        head   = mem_q[rd_ptr_q];
        count6 = 6'(count_q);
        rd_dat = '0;
        if (sel && rd_peri) begin
            case (addr_peri[2:0])
                3'd0:    rd_dat = not_empty ? head[53:36] : '0;
                3'd1:    rd_dat = not_empty ? head[71:54] : '0;
                3'd2:    rd_dat = not_empty ? head[17:0]  : '0;
                3'd3:    rd_dat = not_empty ? head[35:18] : '0;
                3'd4:    rd_dat = {9'd0, count6, ovf_q, full, not_empty};
                3'd5:    rd_dat = {14'd0, ctrl_q};
                default: rd_dat = '0;
            endcase
        end
    end

    assign di_peri = rd_dat;
    assign irq     = irq_q;

endmodule
